issue_ctrl: RTL and testbench

// - Dual-issue dispatch scheduler between the instruction buffer head and the execute stage.
// - Each cycle, inspects the two oldest buffer entries and drives o_size (0/1/2), the buffer's pop count.
// - Owns the long-latency register scoreboard, an in-flight instruction counter and a serialization FSM.
// - The FSM serializes CSR/ertn/idle-class instructions and excepting instructions.

---
 rtl/issue_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_issue_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl
// Dual-issue dispatch scheduler sitting between the instruction buffer head and
// the execute stage. Each cycle it looks at the two oldest buffer entries (a is
// the older one) and decides how many of them leave the buffer (o_size).
// It owns the long-latency register scoreboard, the in-flight instruction
// counter and a small FSM that serializes CSR/ertn/idle-class and excepting
// instructions.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   flush             pipeline redirect: kills everything in flight
//   a_* / b_*         buffer entry 0 / entry 1: valid, kind, dest, r1, r2, excp
//   ex_ready          execute stage accepts a group this cycle
//   wb_vld, wb_dest*  long-latency writebacks clearing scoreboard bits
//   commit_cnt        instructions retired this cycle (0..2)
//   o_size            entries popped/issued this cycle (0..2)
//   o_a_issue/o_b_issue  per-entry issue strobes (b implies a)
//   busy_mask         scoreboard, bit 0 always clear
//   state             FSM state (RUN=0, DRAIN=1, HOLD=2)
// -----------------------------------------------------------------------------
module issue_ctrl #(
    parameter int MAX_INFLIGHT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        a_valid,
    input  logic [2:0]  a_kind,
    input  logic [4:0]  a_dest,
    input  logic [4:0]  a_r1,
    input  logic [4:0]  a_r2,
    input  logic        a_have_excp,
    input  logic        b_valid,
    input  logic [2:0]  b_kind,
    input  logic [4:0]  b_dest,
    input  logic [4:0]  b_r1,
    input  logic [4:0]  b_r2,
    input  logic        b_have_excp,
    input  logic        ex_ready,
    input  logic [1:0]  wb_vld,
    input  logic [4:0]  wb_dest0,
    input  logic [4:0]  wb_dest1,
    input  logic [1:0]  commit_cnt,
    output logic [1:0]  o_size,
    output logic        o_a_issue,
    output logic        o_b_issue,
    output logic [31:0] busy_mask,
    output logic [1:0]  state
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW:0] MAX_W = (CW+1)'(MAX_INFLIGHT);

    localparam logic [2:0] K_BR     = 3'd1;
    localparam logic [2:0] K_MEM    = 3'd2;
    localparam logic [2:0] K_MULDIV = 3'd3;
    localparam logic [2:0] K_SERIAL = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [31:0]    busy_q, busy_d;

    logic           a_ser_s, b_ser_s, a_haz_s, b_haz_s;
    logic           room1_s, room2_s, idle_s;
    logic           a_ok_s, b_ok_s, pair_ok_s;
    logic           kill_s;
    logic [CW:0]    sum_s, cmt_s;
    logic [31:0]    set_s, clr_s;

    // RAW + WAW check against the scoreboard; reg 0 is never marked busy.
    function automatic logic sb_haz(input logic [31:0] busy, input logic [4:0] d,
                                    input logic [4:0] r1, input logic [4:0] r2);
        return busy[d] | busy[r1] | busy[r2];
    endfunction

    // Kinds 4..7 and anything carrying an exception go through the FSM alone.
    function automatic logic is_serial(input logic [2:0] kind, input logic excp);
        return (kind >= K_SERIAL) | excp;
    endfunction

    // Only MEM and MULDIV results come back late enough to need the scoreboard.
    function automatic logic is_long(input logic [2:0] kind);
        return (kind == K_MEM) | (kind == K_MULDIV);
    endfunction

    // One-hot mask of a register, gated by an enable.
    function automatic logic [31:0] reg_bit(input logic en, input logic [4:0] r);
        return {32{en}} & (32'd1 << r);
    endfunction

    assign kill_s = reset | flush;

    // Issue decision for the two head entries.
    always_comb begin
        a_ser_s = is_serial(a_kind, a_have_excp);
        b_ser_s = is_serial(b_kind, b_have_excp);
        a_haz_s = sb_haz(busy_q, a_dest, a_r1, a_r2);
        b_haz_s = sb_haz(busy_q, b_dest, b_r1, b_r2);
        idle_s  = (inflight_q == {CW{1'b0}});
        room1_s = (({1'b0, inflight_q} + (CW+1)'(1)) <= MAX_W);
        room2_s = (({1'b0, inflight_q} + (CW+1)'(2)) <= MAX_W);

        case (state_q)
            ST_RUN:   a_ok_s = a_valid & ex_ready & room1_s & ~a_haz_s & (~a_ser_s | idle_s);
            ST_DRAIN: a_ok_s = a_valid & ex_ready & idle_s & ~a_haz_s;
            default:  a_ok_s = 1'b0;
        endcase

        // Pairing rules: branch closes the group, one MEM port, one MULDIV unit,
        // no RAW or WAW between a and b inside the group.
        pair_ok_s = ~a_ser_s & ~b_ser_s & (a_kind != K_BR)
                  & ~((a_kind == b_kind) & is_long(a_kind))
                  & ~((a_dest != 5'd0) & ((a_dest == b_r1) | (a_dest == b_r2) | (a_dest == b_dest)));

        b_ok_s = a_ok_s & (state_q == ST_RUN) & b_valid & room2_s & ~b_haz_s & pair_ok_s;

        o_a_issue = a_ok_s & ~kill_s;
        o_b_issue = b_ok_s & ~kill_s;
        o_size    = {1'b0, o_a_issue} + {1'b0, o_b_issue};
    end

    // Next-state for scoreboard, in-flight counter and FSM.
    always_comb begin
        busy_d     = busy_q;
        inflight_d = inflight_q;
        state_d    = state_q;

        clr_s = reg_bit(wb_vld[0], wb_dest0) | reg_bit(wb_vld[1], wb_dest1);
        set_s = reg_bit(o_a_issue & is_long(a_kind), a_dest)
              | reg_bit(o_b_issue & is_long(b_kind), b_dest);

        sum_s = {1'b0, inflight_q} + {{(CW-1){1'b0}}, o_size};
        cmt_s = {{(CW-1){1'b0}}, commit_cnt};

        if (flush) begin
            // Flush discards same-cycle commits and writebacks.
            busy_d     = 32'd0;
            inflight_d = {CW{1'b0}};
            state_d    = ST_RUN;
        end else begin
            // Set after clear so a new producer wins over an old writeback.
            busy_d = ((busy_q & ~clr_s) | set_s) & ~32'd1;

            if (cmt_s > sum_s) begin
                inflight_d = {CW{1'b0}};
            end else begin
                inflight_d = CW'(sum_s - cmt_s);
            end

            case (state_q)
                ST_RUN: begin
                    if (o_a_issue & a_ser_s) begin
                        state_d = ST_HOLD;
                    end else if (a_valid & a_ser_s & ~idle_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (o_a_issue) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    // The serialized instruction has retired once nothing is left.
                    if (inflight_d == {CW{1'b0}}) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            inflight_q <= {CW{1'b0}};
            busy_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
        end
    end

    assign busy_mask = busy_q;
    assign state     = state_q;

    issue_ctrl_chk #(.CW(CW)) u_chk (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .a_valid    (a_valid),
        .commit_cnt (commit_cnt),
        .inflight   (inflight_q),
        .state      (state_q)
    );

endmodule

// -----------------------------------------------------------------------------
// issue_ctrl_chk
// Protocol checks on the inputs of issue_ctrl: retirements never exceed what
// is in flight, and the buffer never presents an empty head while draining.
// -----------------------------------------------------------------------------
module issue_ctrl_chk #(
    parameter int CW = 5
) (
    input logic          clk,
    input logic          reset,
    input logic          flush,
    input logic          a_valid,
    input logic [1:0]    commit_cnt,
    input logic [CW-1:0] inflight,
    input logic [1:0]    state
);

    // More retirements than issued instructions is an upstream bug.
    a_commit_le_inflight: assert property (@(posedge clk) disable iff (reset || flush)
        ({{(CW-1){1'b0}}, commit_cnt} <= {1'b0, inflight}));

    // The buffer only empties on flush, so a drained head must still be there.
    a_drain_head_valid: assert property (@(posedge clk) disable iff (reset || flush)
        (state == 2'd1) |-> a_valid);

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;

    typedef struct packed {
        logic       v;
        logic [2:0] k;
        logic [4:0] d;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       e;
    } instr_t;

    localparam int MAXI = 16;
    localparam int RUN = 0, DRAIN = 1, HOLD = 2;

    logic        clk = 1'b0;
    logic        reset, flush, ex_ready;
    instr_t      ia, ib;
    logic [1:0]  wb_vld, commit_cnt;
    logic [4:0]  wb_dest0, wb_dest1;
    logic [1:0]  o_size, state;
    logic        o_a_issue, o_b_issue;
    logic [31:0] busy_mask;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit [31:0] m_busy;
    int        m_inflight;
    int        m_state;

    issue_ctrl #(.MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .a_valid(ia.v), .a_kind(ia.k), .a_dest(ia.d), .a_r1(ia.r1), .a_r2(ia.r2), .a_have_excp(ia.e),
        .b_valid(ib.v), .b_kind(ib.k), .b_dest(ib.d), .b_r1(ib.r1), .b_r2(ib.r2), .b_have_excp(ib.e),
        .ex_ready(ex_ready), .wb_vld(wb_vld), .wb_dest0(wb_dest0), .wb_dest1(wb_dest1),
        .commit_cnt(commit_cnt), .o_size(o_size), .o_a_issue(o_a_issue), .o_b_issue(o_b_issue),
        .busy_mask(busy_mask), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input int v, input int k, input int d, input int r1, input int r2);
        instr_t x;
        x.v = v[0]; x.k = k[2:0]; x.d = d[4:0]; x.r1 = r1[4:0]; x.r2 = r2[4:0]; x.e = 1'b0;
        return x;
    endfunction

    function automatic bit m_serial(input instr_t x);
        return (int'(x.k) >= 4) || x.e;
    endfunction

    function automatic bit m_haz(input instr_t x);
        return m_busy[x.d] || m_busy[x.r1] || m_busy[x.r2];
    endfunction

    function automatic bit m_long(input instr_t x);
        return (x.k == 3'd2) || (x.k == 3'd3);
    endfunction

    // What the scheduler should issue this cycle, from the rules directly.
    task automatic model_issue(output bit ea, output bit eb);
        ea = 0; eb = 0;
        if (reset || flush) return;
        if (m_state == RUN)
            ea = ia.v && ex_ready && (m_inflight + 1 <= MAXI) && !m_haz(ia) && (!m_serial(ia) || m_inflight == 0);
        else if (m_state == DRAIN)
            ea = ia.v && ex_ready && (m_inflight == 0) && !m_haz(ia);
        if (!ea || m_state != RUN || !ib.v) return;
        if (m_inflight + 2 > MAXI || m_haz(ib)) return;
        if (m_serial(ia) || m_serial(ib) || ia.k == 3'd1) return;
        if (ia.k == ib.k && m_long(ia)) return;
        if (ia.d != 0 && (ia.d == ib.r1 || ia.d == ib.r2 || ia.d == ib.d)) return;
        eb = 1;
    endtask

    task automatic model_update(input bit ea, input bit eb);
        int n;
        if (reset || flush) begin
            m_busy = 0; m_inflight = 0; m_state = RUN;
            return;
        end
        n = m_inflight + int'(ea) + int'(eb) - int'(commit_cnt);
        if (n < 0) n = 0;
        if (wb_vld[0]) m_busy[wb_dest0] = 1'b0;
        if (wb_vld[1]) m_busy[wb_dest1] = 1'b0;
        if (ea && m_long(ia) && ia.d != 0) m_busy[ia.d] = 1'b1;
        if (eb && m_long(ib) && ib.d != 0) m_busy[ib.d] = 1'b1;
        if (m_state == RUN) begin
            if (ea && m_serial(ia)) m_state = HOLD;
            else if (ia.v && m_serial(ia) && m_inflight != 0) m_state = DRAIN;
        end else if (m_state == DRAIN) begin
            if (ea) m_state = HOLD;
        end else if (n == 0) begin
            m_state = RUN;
        end
        m_inflight = n;
    endtask

    // One clock: sample at negedge, compare against the model, advance on posedge.
    task automatic step(input string tag, input int exp_size);
        bit ea, eb;
        @(negedge clk);
        model_issue(ea, eb);
        if (exp_size >= 0) check(tag, {30'd0, o_size}, exp_size);
        check({tag, "_a"}, {31'd0, o_a_issue}, {31'd0, ea});
        check({tag, "_b"}, {31'd0, o_b_issue}, {31'd0, eb});
        check({tag, "_sz"}, {30'd0, o_size}, int'(ea) + int'(eb));
        check({tag, "_st"}, {30'd0, state}, m_state);
        check({tag, "_busy"}, busy_mask, m_busy);
        @(posedge clk);
        #1;
        model_update(ea, eb);
    endtask

    task automatic idle_inputs();
        ia = '0; ib = '0; flush = 1'b0; ex_ready = 1'b1;
        wb_vld = 2'b00; wb_dest0 = 5'd0; wb_dest1 = 5'd0; commit_cnt = 2'd0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        reset = 1'b1;
        step(tag, 0);
        reset = 1'b0;
        check({tag, "_state"}, {30'd0, state}, 0);
        check({tag, "_busy0"}, busy_mask, 0);
    endtask

    function automatic instr_t rand_instr();
        instr_t x;
        x.v  = ($urandom_range(0, 7) != 0);
        x.k  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        x.d  = 5'($urandom_range(0, 7));
        x.r1 = 5'($urandom_range(0, 7));
        x.r2 = 5'($urandom_range(0, 7));
        x.e  = ($urandom_range(0, 31) == 0);
        return x;
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b1;
        m_busy = 0; m_inflight = 0; m_state = RUN;
        @(posedge clk);
        #1;
        do_reset("rst");

        // 1: two independent ALU ops pair up
        ia = mk(1, 0, 3, 1, 0); ib = mk(1, 0, 4, 2, 0);
        step("t1_size", 2);

        // 2: MEM producer blocks its consumer until writeback
        ia = mk(1, 2, 5, 0, 0); ib = mk(1, 0, 6, 5, 0);
        step("t2_size", 1);
        check("t2_busy5", {31'd0, busy_mask[5]}, 1);
        ia = mk(1, 0, 6, 5, 0); ib = '0;
        step("t2_stall", 0);
        wb_vld = 2'b01; wb_dest0 = 5'd5;
        step("t2_stall_wb", 0);
        check("t2_busy5_clr", {31'd0, busy_mask[5]}, 0);
        wb_vld = 2'b00;
        step("t2_go", 1);

        // 3: structural / branch / WAW limits
        ia = mk(1, 3, 0, 1, 2); ib = mk(1, 3, 0, 3, 0);
        step("t3_muldiv", 1);
        ia = mk(1, 1, 0, 1, 0); ib = mk(1, 0, 12, 2, 0);
        step("t3_branch", 1);
        ia = mk(1, 0, 7, 1, 0); ib = mk(1, 0, 7, 2, 0);
        step("t3_waw", 1);

        // 4: serial instruction drains, issues alone, then holds
        do_reset("t4_rst");
        ia = mk(1, 0, 10, 1, 0); ib = mk(1, 0, 11, 2, 0);
        step("t4_fill2", 2);
        ib = '0;
        step("t4_fill1", 1);
        ia = mk(1, 4, 0, 0, 0); ib = mk(1, 0, 12, 1, 0);
        step("t4_stall", 0);
        check("t4_drain", {30'd0, state}, DRAIN);
        commit_cnt = 2'd2;
        step("t4_drain1", 0);
        commit_cnt = 2'd1;
        step("t4_drain2", 0);
        commit_cnt = 2'd0;
        step("t4_issue", 1);
        check("t4_hold", {30'd0, state}, HOLD);
        ia = mk(1, 0, 12, 1, 0); ib = '0;
        step("t4_held", 0);
        commit_cnt = 2'd1;
        step("t4_release", 0);
        check("t4_run", {30'd0, state}, RUN);
        commit_cnt = 2'd0;
        step("t4_resume", 1);

        // 5: in-flight limit
        do_reset("t5_rst");
        for (int i = 0; i < 7; i++) begin
            ia = mk(1, 0, 10, 1, 0); ib = mk(1, 0, 11, 2, 0);
            step("t5_fill", 2);
        end
        ib = '0;
        step("t5_fill15", 1);
        ib = mk(1, 0, 11, 2, 0);
        step("t5_room1", 1);
        commit_cnt = 2'd2;
        step("t5_full", 0);
        commit_cnt = 2'd0;
        step("t5_after", 2);

        // 6: flush out of HOLD with a pending busy register
        do_reset("t6_rst");
        ia = mk(1, 2, 9, 0, 0);
        step("t6_mem", 1);
        ia = '0; commit_cnt = 2'd1;
        step("t6_commit", 0);
        commit_cnt = 2'd0; ia = mk(1, 4, 0, 0, 0);
        step("t6_serial", 1);
        check("t6_hold", {30'd0, state}, HOLD);
        check("t6_busy9", {31'd0, busy_mask[9]}, 1);
        ia = mk(1, 0, 1, 2, 0); flush = 1'b1; wb_vld = 2'b01; wb_dest0 = 5'd9; commit_cnt = 2'd1;
        step("t6_flush", 0);
        check("t6_state_run", {30'd0, state}, RUN);
        check("t6_busy_zero", busy_mask, 0);
        flush = 1'b0; wb_vld = 2'b00; commit_cnt = 2'd0; ia = mk(1, 4, 0, 0, 0);
        step("t6_inflight0", 1);

        // Randomized traffic against the model
        do_reset("rnd_rst");
        for (int n = 0; n < 3000; n++) begin
            int mx;
            if (m_state != DRAIN) ia = rand_instr();
            ib = rand_instr();
            ex_ready = ($urandom_range(0, 4) != 0);
            flush = ($urandom_range(0, 59) == 0);
            mx = (m_inflight < 2) ? m_inflight : 2;
            commit_cnt = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, mx)) : 2'd0;
            wb_vld = 2'($urandom_range(0, 3));
            wb_dest0 = 5'($urandom_range(0, 7));
            wb_dest1 = 5'($urandom_range(0, 7));
            step("rnd", -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
